// File: rtl/cpu_pkg.sv
// Shared encodings for the ID-stage hazard logic and the result-latency helper
// used to preload the per-register scoreboard counters.
package cpu_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_MUL  = 2'd2,
    KIND_NONE = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_RAW     = 2'd1,
    CAUSE_WAW     = 2'd2,
    CAUSE_MULBUSY = 2'd3
  } cause_e;

  // Countdown value loaded into a destination tracker when its producer issues.
  function automatic int latency(input logic [1:0] kind, input int mem_lat,
                                 input int mul_lat, input int early_extra);
    case (kind)
      KIND_LOAD: latency = mem_lat - 1 + early_extra;
      KIND_MUL:  latency = mul_lat - 1 + early_extra;
      default:   latency = 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: a loadable down-counter that saturates at zero.
module sb_entry #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - W'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector: per-register countdown scoreboard for load/mul
// results, early-consumer penalties, WAW protection and multiplier busy stalls.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int MEM_LAT     = 2,
  parameter int MUL_LAT     = 4,
  parameter int EARLY_EXTRA = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_early,
  input  logic [4:0] id_rd,
  input  logic [1:0] id_kind,
  output logic       stall,
  output logic [1:0] stall_cause,
  output logic       mul_busy
);

  localparam int MAX_LAT = ((MEM_LAT > MUL_LAT) ? MEM_LAT : MUL_LAT) + EARLY_EXTRA;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CW-1:0] EE_C      = CW'(EARLY_EXTRA);
  localparam logic [CW-1:0] BUSY_INIT = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt [32];
  logic [CW-1:0] new_val;
  logic [CW-1:0] rs_cnt;
  logic [CW-1:0] rt_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] busy_cnt;
  logic          writes;
  logic          raw_rs;
  logic          raw_rt;
  logic          raw;
  logic          waw;
  logic          mul_conflict;
  logic          issue;

  // Register 0 is hardwired; it never carries a pending result.
  assign cnt[0] = '0;

  for (genvar i = 1; i < 32; i++) begin : g_entry
    logic load;
    assign load = issue && writes && (id_rd == 5'(i));
    sb_entry #(.W(CW)) u_entry (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .value (new_val),
      .count (cnt[i])
    );
  end

  assign new_val = CW'(latency(id_kind, MEM_LAT, MUL_LAT, EARLY_EXTRA));
  assign writes  = (id_rd != 5'd0) && (id_kind != KIND_NONE);
  assign rs_cnt  = cnt[id_rs];
  assign rt_cnt  = cnt[id_rt];
  assign rd_cnt  = cnt[id_rd];

  // Late consumers tolerate EARLY_EXTRA leftover cycles; ID-stage consumers need zero.
  assign raw_rs = id_use_rs && (id_rs != 5'd0) &&
                  ((rs_cnt > EE_C) || (id_early && (rs_cnt != '0)));
  assign raw_rt = id_use_rt && (id_rt != 5'd0) &&
                  ((rt_cnt > EE_C) || (id_early && (rt_cnt != '0)));
  assign raw    = raw_rs || raw_rt;

  assign waw          = writes && (rd_cnt > new_val);
  assign mul_conflict = (id_kind == KIND_MUL) && mul_busy;

  assign stall = id_valid && (raw || waw || mul_conflict);
  assign issue = id_valid && !stall;

  always_comb begin
    stall_cause = CAUSE_NONE;
    if (stall) begin
      if (raw)
        stall_cause = CAUSE_RAW;
      else if (waw)
        stall_cause = CAUSE_WAW;
      else
        stall_cause = CAUSE_MULBUSY;
    end
  end

  // The multiplier is not pipelined: one operation occupies it for MUL_LAT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy_cnt <= '0;
    else if (issue && (id_kind == KIND_MUL))
      busy_cnt <= BUSY_INIT;
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - CW'(1);
  end

  assign mul_busy = (busy_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a timestamp-based reference model predicts
// stall/cause/mul_busy each cycle; a monitor compares against the DUT.
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  localparam int MEM_LAT     = 2;
  localparam int MUL_LAT     = 4;
  localparam int EARLY_EXTRA = 1;
  localparam int MAX_STALL   = MUL_LAT - 1 + EARLY_EXTRA;
  localparam int N_RANDOM    = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_use_rs = 1'b0;
  logic       id_use_rt = 1'b0;
  logic       id_early = 1'b0;
  logic [4:0] id_rd = '0;
  logic [1:0] id_kind = KIND_NONE;
  logic       stall;
  logic [1:0] stall_cause;
  logic       mul_busy;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .MEM_LAT     (MEM_LAT),
    .MUL_LAT     (MUL_LAT),
    .EARLY_EXTRA (EARLY_EXTRA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_early    (id_early),
    .id_rd       (id_rd),
    .id_kind     (id_kind),
    .stall       (stall),
    .stall_cause (stall_cause),
    .mul_busy    (mul_busy)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] cause;
    logic       mul_busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model in absolute cycle numbers: when each register's value becomes
  // usable by a normal / ID-stage consumer, and when the multiplier frees up.
  int ready_n [32];
  int ready_e [32];
  int mul_free;

  int run = 0;
  int last_run = 0;
  logic [1:0] run_cause = CAUSE_NONE;
  logic [1:0] last_cause = CAUSE_NONE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req)
      passes++;
    else
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int use_delay(input logic [1:0] k);
    case (k)
      KIND_LOAD: return MEM_LAT;
      KIND_MUL:  return MUL_LAT;
      default:   return 1;
    endcase
  endfunction

  function automatic int early_delay(input logic [1:0] k);
    case (k)
      KIND_LOAD: return MEM_LAT + EARLY_EXTRA;
      KIND_MUL:  return MUL_LAT + EARLY_EXTRA;
      default:   return 1;
    endcase
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_n[r] = 0;
      ready_e[r] = 0;
    end
    mul_free = 0;
  endfunction

  function automatic bit src_blocked(input bit used, input logic [4:0] r, input int c);
    if (!used || r == 5'd0) return 1'b0;
    return id_early ? (c < ready_e[r]) : (c < ready_n[r]);
  endfunction

  function automatic exp_t predict(input int c);
    exp_t e;
    bit raw, waw, mb;
    raw = src_blocked(id_use_rs, id_rs, c) || src_blocked(id_use_rt, id_rt, c);
    // A younger write must land strictly after the older pending one.
    waw = (id_rd != 5'd0) && (id_kind != KIND_NONE) &&
          (c + early_delay(id_kind) <= ready_e[id_rd]);
    mb  = (id_kind == KIND_MUL) && (c < mul_free);
    e.mul_busy = (c < mul_free);
    e.stall    = id_valid && (raw || waw || mb);
    e.cause    = !e.stall ? CAUSE_NONE : raw ? CAUSE_RAW : waw ? CAUSE_WAW : CAUSE_MULBUSY;
    return e;
  endfunction

  function automatic void commit(input int c);
    if (id_rd != 5'd0 && id_kind != KIND_NONE) begin
      ready_n[id_rd] = c + use_delay(id_kind);
      ready_e[id_rd] = c + early_delay(id_kind);
    end
    if (id_kind == KIND_MUL) mul_free = c + MUL_LAT;
  endfunction

  task automatic set_instr(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input bit urs, input bit urt, input bit early);
    id_valid  = 1'b1;
    id_kind   = k;
    id_rd     = rd;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_early  = early;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      id_valid = 1'b0;
      e = predict(cyc);
      exp_q.push_back(e);
      @(negedge clk); #1;
    end
  endtask

  // Holds the instruction in ID until the model says it issues.
  task automatic present(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input bit urs, input bit urt, input bit early);
    exp_t e;
    int   waited;
    waited = 0;
    forever begin
      @(posedge clk); #1;
      set_instr(k, rd, rs, rt, urs, urt, early);
      e = predict(cyc);
      exp_q.push_back(e);
      @(negedge clk); #1;
      if (!e.stall) begin
        commit(cyc);
        break;
      end
      waited++;
      if (waited > MAX_STALL + 1) begin
        chk("model_release", waited, MAX_STALL);
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("stall_cause", int'(stall_cause), int'(e.cause));
      chk("mul_busy", int'(mul_busy), int'(e.mul_busy));
      if (id_valid && stall) begin
        run++;
        run_cause = stall_cause;
      end else if (id_valid) begin
        chk("stall_len_bound", int'(run <= MAX_STALL), 1);
        last_run   = run;
        last_cause = run_cause;
        run        = 0;
        run_cause  = CAUSE_NONE;
      end
    end
  end

  initial begin
    exp_t e;
    model_reset();
    set_instr(KIND_MUL, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_cause", int'(stall_cause), int'(CAUSE_NONE));
    chk("reset_mul_busy", int'(mul_busy), 0);
    id_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    present(KIND_LOAD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    present(KIND_ALU, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lw_use_bubbles", last_run, 1);
    chk("lw_use_cause", int'(last_cause), int'(CAUSE_RAW));
    idle(6);

    present(KIND_LOAD, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    present(KIND_NONE, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("lw_jr_bubbles", last_run, 2);
    chk("lw_jr_cause", int'(last_cause), int'(CAUSE_RAW));
    idle(6);

    present(KIND_ALU, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    present(KIND_NONE, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("alu_jr_bubbles", last_run, 0);
    idle(6);

    present(KIND_MUL, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    present(KIND_MUL, 5'd10, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("mul_mul_bubbles", last_run, 3);
    chk("mul_mul_cause", int'(last_cause), int'(CAUSE_MULBUSY));
    idle(6);

    // The mul's tracker starts at MUL_LAT-1+EARLY_EXTRA, so the ALU write waits it out.
    present(KIND_MUL, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    present(KIND_ALU, 5'd9, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
    chk("mul_waw_bubbles", last_run, 4);
    chk("mul_waw_cause", int'(last_cause), int'(CAUSE_WAW));
    idle(6);

    present(KIND_LOAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    present(KIND_ALU, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("reg0_bubbles", last_run, 0);
    present(KIND_LOAD, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    present(KIND_ALU, 5'd6, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("unused_rt_bubbles", last_run, 0);
    idle(6);

    // Asynchronous reset for half a cycle in the middle of a multiplier stall.
    present(KIND_MUL, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_instr(KIND_MUL, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    e = predict(cyc);
    exp_q.push_back(e);
    @(negedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_mul_busy", int'(mul_busy), 0);
    chk("midrst_cause", int'(stall_cause), int'(CAUSE_NONE));
    model_reset();
    e = predict(cyc);
    exp_q.push_back(e);
    @(negedge clk); #1;
    reset = 1'b1;
    if (!e.stall) commit(cyc);
    present(KIND_ALU, 5'd3, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(6);

    for (int n = 0; n < N_RANDOM; n++) begin
      if ($urandom_range(4) == 0) idle(1);
      present(2'($urandom_range(3)), 5'($urandom_range(7)), 5'($urandom_range(7)),
              5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              ($urandom_range(3) == 0));
    end
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
